// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, read-only, one-word-per-block instruction
// cache. It answers datapath fetches (imemREN/imemaddr -> ihit/imemload) and
// refills misses through a single-word, wait-stated port (iREN/iaddr <- iwait/iload).
//
// Handshakes: a fetch is served in the same cycle whenever ihit=1. A fill is a
// level request: iREN stays high with a stable iaddr until the first cycle
// with iwait=0. That cycle is the data beat, and iload is captured on it.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state;
  logic [29:0]       fill_word;   // word address of the outstanding fill
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              unused_byte_off;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = fill_word[IDX_W-1:0];
  assign fill_tag = fill_word[29:IDX_W];
  // Byte offset within the word has no meaning for instruction fetch.
  assign unused_byte_off = ^imemaddr[1:0];

  // Tag lookup for the current fetch request.
  always_comb begin
    hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  end

  // Output decode: hits are answered combinationally; a flush masks them.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    if (state == IDLE) begin
      if (hit && !flush) begin
        ihit     = 1'b1;
        imemload = data_q[req_idx];
      end
    end else begin
      iREN  = 1'b1;
      iaddr = {fill_word, 2'b00};
    end
  end

  // Control FSM plus storage update: miss detect, fill write-back, flush/abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      fill_word <= '0;
      valid_q   <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            // Flush wins over any request; the request retries as a miss.
            valid_q <= '0;
          end else if (imemREN && !hit) begin
            fill_word <= imemaddr[31:2];
            state     <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            // Abort: the beat is dropped even if it arrives this cycle.
            valid_q <= '0;
            state   <= IDLE;
          end else if (!iwait) begin
            // Unconditional overwrite; a redirected fetch is looked up afterwards.
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= iload;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: table of fetch vectors, random fetches against a
// small tag model, and hand-written sequences for redirect, flush and reset.
module tb_icache_responder;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache_responder dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- counters, scoreboard, model ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  bit          ref_valid [16];
  logic [25:0] ref_tag   [16];
  int          lat_cfg = 0;
  int          wait_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    int          lat;
  } vec_t;
  vec_t vecs [11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_0004: return 32'h8C22_0000;
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0040: return 32'h2222_2222;
      default:       return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask

  function automatic bit model_miss(input logic [31:0] a);
    return !(ref_valid[a[5:2]] && ref_tag[a[5:2]] == a[31:6]);
  endfunction

  // Memory side: iwait stays high for lat_cfg cycles of iREN, then one data beat.
  initial begin
    iwait = 1'b1;
    iload = 32'h0;
    forever begin
      @(negedge CLK);
      if (iREN) begin
        if (wait_cnt < lat_cfg) begin
          iwait = 1'b1;
          wait_cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
        end
      end else begin
        iwait    = 1'b1;
        wait_cnt = 0;
      end
    end
  end

  // Driver: issue one fetch, push its expected word, pop and compare on ihit.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_d,
                       input bit exp_miss, input int lat, input string name);
    int cyc;
    int ren_cyc;
    bit got;
    cyc = 0; ren_cyc = 0; got = 1'b0;
    lat_cfg = lat;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = addr;
    exp_q.push_back(exp_d);
    while (!got && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (ihit) got = 1'b1;
      else if (iREN) begin
        ren_cyc++;
        check({name, "_iaddr"}, iaddr, {addr[31:2], 2'b00});
      end
    end
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      check({name, "_data"}, imemload, exp_q.pop_front());
      check({name, "_lat"}, 32'(cyc), exp_miss ? 32'(lat + 3) : 32'd1);
      check({name, "_iren_cycles"}, 32'(ren_cyc), exp_miss ? 32'(lat + 1) : 32'd0);
      ref_valid[addr[5:2]] = 1'b1;
      ref_tag[addr[5:2]]   = addr[31:6];
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic fetch_m(input logic [31:0] addr, input int lat, input string name);
    fetch(addr, mem_word(addr), model_miss(addr), lat, name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit done;
    logic [31:0] a;

    vecs[0]  = '{32'h0000_0004, 32'h8C22_0000, 1'b1, 3};
    vecs[1]  = '{32'h0000_0006, 32'h8C22_0000, 1'b0, 0};
    vecs[2]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 1};
    vecs[3]  = '{32'h0000_0040, 32'h2222_2222, 1'b1, 2};
    vecs[4]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 0};
    vecs[5]  = '{32'h0000_0044, mem_word(32'h44), 1'b1, 1};
    vecs[6]  = '{32'h0000_0004, 32'h8C22_0000, 1'b1, 0};
    vecs[7]  = '{32'h0000_0007, 32'h8C22_0000, 1'b0, 0};
    vecs[8]  = '{32'h0000_003C, mem_word(32'h3C), 1'b1, 4};
    vecs[9]  = '{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 0};
    vecs[10] = '{32'h0000_003C, mem_word(32'h3C), 1'b1, 1};

    RST = 1'b1; flush = 1'b0; imemREN = 1'b1; imemaddr = 32'h4;
    model_clear();
    #3;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Table vectors: miss/hit, conflicts, byte offset, index/tag extremes.
    for (int i = 0; i < 11; i++)
      fetch(vecs[i].addr, vecs[i].data, vecs[i].miss, vecs[i].lat, $sformatf("vec%0d", i));

    // Random fetches across 4 tags x 16 sets against the tag model.
    for (int i = 0; i < 12; i++) begin
      a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      fetch_m(a, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Redirect during a fill: latched address completes, then new one misses.
    fetch_m(32'h0, 0, "redir_prep");
    lat_cfg = 2;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h10;
    @(negedge CLK);
    check("redir_detect_iren", {31'd0, iREN}, 32'd0);
    @(negedge CLK);
    check("redir_fill1_iren", {31'd0, iREN}, 32'd1);
    check("redir_fill1_iaddr", iaddr, 32'h10);
    @(posedge CLK); #1;
    imemaddr = 32'h80;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge CLK);
      if (!iREN) done = 1'b1;
      else begin
        check("redir_iaddr_held", iaddr, 32'h10);
        n++;
      end
    end
    check("redir_fill_len", 32'(n), 32'd2);
    check("redir_new_ihit", {31'd0, ihit}, 32'd0);
    ref_valid[4] = 1'b1; ref_tag[4] = 26'd0;
    exp_q.push_back(mem_word(32'h80));
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge CLK);
      n++;
      if (ihit) done = 1'b1;
      else if (iREN) check("redir_new_iaddr", iaddr, 32'h80);
    end
    if (!done) begin
      check("redir_new_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      check("redir_new_data", imemload, exp_q.pop_front());
      check("redir_new_lat", 32'(n), 32'd4);
    end
    ref_valid[0] = 1'b1; ref_tag[0] = 26'd2;
    @(posedge CLK); #1 imemREN = 1'b0;
    fetch(32'h10, mem_word(32'h10), 1'b0, 0, "redir_set4_hit");

    // Flush in IDLE with a concurrent request that would have hit.
    fetch_m(32'h0, 0, "flush_prep0");
    fetch_m(32'h4, 0, "flush_prep1");
    @(posedge CLK); #1;
    flush = 1'b1; imemREN = 1'b1; imemaddr = 32'h0;
    @(negedge CLK);
    check("flush_idle_ihit", {31'd0, ihit}, 32'd0);
    check("flush_idle_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0; imemREN = 1'b0;
    @(negedge CLK);
    check("flush_idle_nofill", {31'd0, iREN}, 32'd0);
    model_clear();
    fetch(32'h0, 32'h1111_1111, 1'b1, 1, "flush_miss0");
    fetch(32'h4, 32'h8C22_0000, 1'b1, 0, "flush_miss1");

    // Flush during FILL on the data beat: nothing written, iREN drops.
    lat_cfg = 0;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h8;
    @(negedge CLK);
    check("abort_detect_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b1; imemREN = 1'b0;
    @(negedge CLK);
    check("abort_beat_iren", {31'd0, iREN}, 32'd1);
    check("abort_beat_iwait", {31'd0, iwait}, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    check("abort_after_iren", {31'd0, iREN}, 32'd0);
    model_clear();
    fetch(32'h8, mem_word(32'h8), 1'b1, 0, "abort_refetch");

    // Asynchronous reset in the middle of a fill.
    fetch_m(32'hC, 0, "rst_prep");
    lat_cfg = 5;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h14;
    @(posedge CLK); #2;
    check("midfill_iren", {31'd0, iREN}, 32'd1);
    check("midfill_iaddr", iaddr, 32'h14);
    #1 RST = 1'b1;
    #1;
    check("async_rst_iren", {31'd0, iREN}, 32'd0);
    check("async_rst_iaddr", iaddr, 32'd0);
    check("async_rst_ihit", {31'd0, ihit}, 32'd0);
    imemREN = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    model_clear();
    fetch(32'hC, mem_word(32'hC), 1'b1, 1, "post_rst_miss");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

endmodule
